// File: rtl/eth_ingress_buf_if.sv
// Ingress-buffer bus: MAC-side packet words in, switch-port words and error counters out.
// The master drives the source side and portStall; the slave is the buffer itself.
interface eth_ingress_buf_if #(
    parameter int unsigned CNTW = 16
);
    logic [31:0]     srcData;
    logic            srcValid;
    logic            srcSop;
    logic            srcEop;
    logic            portStall;
    logic [31:0]     inData;
    logic            inValid;
    logic            inSop;
    logic            inEop;
    logic [CNTW-1:0] dropCnt;
    logic [CNTW-1:0] errCnt;

    modport master (
        output srcData, srcValid, srcSop, srcEop, portStall,
        input  inData, inValid, inSop, inEop, dropCnt, errCnt
    );

    modport slave (
        input  srcData, srcValid, srcSop, srcEop, portStall,
        output inData, inValid, inSop, inEop, dropCnt, errCnt
    );
endinterface

// File: rtl/eth_ingress_buf.sv
// Store-and-forward Ethernet ingress buffer: packets are written speculatively, committed on
// eop, dropped when space runs out, and issued to the switch port only once complete.
module eth_ingress_buf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNTW  = 16
) (
    input logic             clk,
    input logic             reset,
    eth_ingress_buf_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthW = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StSend, StLast} rdStateT;

    logic [33:0]     mem [DEPTH];
    logic [AW-1:0]   wrPtrQ, specPtrQ, rdPtrQ;
    logic [CW-1:0]   wordCntQ, specCntQ, pktCntQ;
    logic            openQ, dropQ;
    logic [CNTW-1:0] dropCntQ, errCntQ;
    rdStateT         stateQ;
    logic [31:0]     inDataQ;
    logic            inValidQ, inSopQ, inEopQ;

    logic            startPkt, full, wrEn, commit, errInc, dropInc, openD, dropD;
    logic            rdFire, pktDec;
    logic [AW-1:0]   basePtr, specPtrD;
    logic [CW-1:0]   baseCnt, specCntD, commitLen, wordCntD;
    logic [33:0]     rdWord;

    assign rdFire = (stateQ == StSend) && !bus.portStall;
    assign pktDec = (stateQ == StLast);
    assign rdWord = mem[rdPtrQ];

    // A new sop always restarts from the committed pointer, which also aborts any open packet.
    always_comb begin
        startPkt  = bus.srcValid && bus.srcSop;
        basePtr   = startPkt ? wrPtrQ : specPtrQ;
        baseCnt   = startPkt ? '0 : specCntQ;
        commitLen = baseCnt + CW'(1);
        full      = (wordCntQ + baseCnt) == DepthW;
        wrEn      = 1'b0;
        commit    = 1'b0;
        errInc    = 1'b0;
        dropInc   = 1'b0;
        openD     = openQ;
        dropD     = dropQ;
        specPtrD  = specPtrQ;
        specCntD  = specCntQ;
        if (bus.srcValid) begin
            if (!bus.srcSop && !openQ) begin
                errInc = 1'b1;
            end else if (!bus.srcSop && dropQ) begin
                if (bus.srcEop) begin
                    openD = 1'b0;
                    dropD = 1'b0;
                end
            end else begin
                errInc = startPkt && openQ;
                if (full) begin
                    dropInc  = 1'b1;
                    specPtrD = wrPtrQ;
                    specCntD = '0;
                    openD    = !bus.srcEop;
                    dropD    = !bus.srcEop;
                end else begin
                    wrEn     = 1'b1;
                    commit   = bus.srcEop;
                    specPtrD = basePtr + AW'(1);
                    specCntD = bus.srcEop ? '0 : commitLen;
                    openD    = !bus.srcEop;
                    dropD    = 1'b0;
                end
            end
        end
        wordCntD = wordCntQ + (commit ? commitLen : '0) - (rdFire ? CW'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[basePtr] <= {bus.srcSop, bus.srcEop, bus.srcData};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtrQ   <= '0;
            specPtrQ <= '0;
            wordCntQ <= '0;
            specCntQ <= '0;
            pktCntQ  <= '0;
            openQ    <= 1'b0;
            dropQ    <= 1'b0;
            dropCntQ <= '0;
            errCntQ  <= '0;
        end else begin
            openQ    <= openD;
            dropQ    <= dropD;
            specPtrQ <= specPtrD;
            specCntQ <= specCntD;
            wordCntQ <= wordCntD;
            if (commit) begin
                wrPtrQ <= specPtrD;
            end
            if (commit && !pktDec) begin
                pktCntQ <= pktCntQ + CW'(1);
            end else if (!commit && pktDec) begin
                pktCntQ <= pktCntQ - CW'(1);
            end
            if (dropInc && (dropCntQ != '1)) begin
                dropCntQ <= dropCntQ + CNTW'(1);
            end
            if (errInc && (errCntQ != '1)) begin
                errCntQ <= errCntQ + CNTW'(1);
            end
        end
    end

    // Read side: outputs are registered; inData only changes when a word is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= StIdle;
            rdPtrQ   <= '0;
            inDataQ  <= '0;
            inValidQ <= 1'b0;
            inSopQ   <= 1'b0;
            inEopQ   <= 1'b0;
        end else begin
            inValidQ <= 1'b0;
            inSopQ   <= 1'b0;
            inEopQ   <= 1'b0;
            unique case (stateQ)
                StIdle: begin
                    if (pktCntQ != '0) begin
                        stateQ <= StSend;
                    end
                end
                StSend: begin
                    if (!bus.portStall) begin
                        inValidQ <= 1'b1;
                        inSopQ   <= rdWord[33];
                        inEopQ   <= rdWord[32];
                        inDataQ  <= rdWord[31:0];
                        rdPtrQ   <= rdPtrQ + AW'(1);
                        if (rdWord[32]) begin
                            stateQ <= StLast;
                        end
                    end
                end
                StLast: stateQ <= StIdle;
                default: stateQ <= StIdle;
            endcase
        end
    end

    assign bus.inData  = inDataQ;
    assign bus.inValid = inValidQ;
    assign bus.inSop   = inSopQ;
    assign bus.inEop   = inEopQ;
    assign bus.dropCnt = dropCntQ;
    assign bus.errCnt  = errCntQ;
endmodule

// File: tb/tb_eth_ingress_buf.sv
// Bench for eth_ingress_buf: packet-level reference model checked every cycle, plus directed
// latency/ordering/drop/error/reset scenarios with literal expectations.
module tb_eth_ingress_buf;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNTW  = 4;
    localparam int MaxCnt = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    eth_ingress_buf_if #(.CNTW(CNTW)) bus ();

    eth_ingress_buf #(
        .DEPTH(DEPTH),
        .CNTW (CNTW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int issuedCnt = 0;

    // Reference model state: words of committed-but-unissued packets, and the open packet.
    bit [33:0] expQ[$];
    bit [33:0] specQ[$];
    bit [33:0] newPkt[$];
    bit mOpen = 0, mDropping = 0, midPkt = 0;
    int mCommitted = 0, mPopped = 0, mDropCnt = 0, mErrCnt = 0;

    logic cV, cS, cE, cStall, cRst;
    logic [31:0] cD;
    logic [31:0] prevData = '0;
    bit [33:0] w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cV = bus.srcValid; cS = bus.srcSop; cE = bus.srcEop; cD = bus.srcData;
        cStall = bus.portStall; cRst = reset;
        #1;
        if (cRst) begin
            chk("rst outputs", {bus.inValid, bus.inSop, bus.inEop, bus.inData}, '0);
            chk("rst counters", {bus.dropCnt, bus.errCnt}, '0);
            expQ.delete(); specQ.delete();
            mOpen = 0; mDropping = 0; midPkt = 0;
            mCommitted = 0; mPopped = 0; mDropCnt = 0; mErrCnt = 0;
        end else begin
            newPkt.delete();
            if (cV) begin
                if (cS) begin
                    if (mOpen && mErrCnt < MaxCnt) mErrCnt++;
                    specQ.delete();
                    mOpen = 1;
                    mDropping = 0;
                end else if (!mOpen && mErrCnt < MaxCnt) begin
                    mErrCnt++;
                end
                if (mOpen) begin
                    if (!mDropping) begin
                        if ((mCommitted - mPopped) + specQ.size() >= DEPTH) begin
                            mDropping = 1;
                            if (mDropCnt < MaxCnt) mDropCnt++;
                            specQ.delete();
                        end else begin
                            specQ.push_back({cS, cE, cD});
                        end
                    end
                    if (cE) begin
                        if (!mDropping) begin
                            newPkt = specQ;
                            mCommitted += specQ.size();
                        end
                        specQ.delete();
                        mOpen = 0;
                        mDropping = 0;
                    end
                end
            end
            chk("dropCnt", bus.dropCnt, mDropCnt);
            chk("errCnt", bus.errCnt, mErrCnt);
            if (cStall) begin
                chk("stall inValid", bus.inValid, 0);
                chk("stall inData", bus.inData, prevData);
            end else if (midPkt) begin
                chk("gap inValid", bus.inValid, 1);
            end
            if (bus.inValid) begin
                issuedCnt++;
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL leak: inValid=1 data 0x%0h with no committed word pending",
                             bus.inData);
                end else begin
                    w = expQ.pop_front();
                    mPopped++;
                    chk("word", {bus.inSop, bus.inEop, bus.inData}, w);
                    midPkt = !w[32];
                end
            end
            foreach (newPkt[i]) expQ.push_back(newPkt[i]);
        end
        prevData = bus.inData;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input bit s, input bit e, input logic [31:0] d);
        bus.srcValid = v; bus.srcSop = s; bus.srcEop = e; bus.srcData = d;
    endtask

    task automatic sendPkt(input logic [31:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            drive(1'b1, i == 0, i == len - 1, base + 32'(i));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic drain(input int maxCyc, input bit toggle);
        int n = 0;
        bus.portStall = toggle;
        while (expQ.size() != 0 && n < maxCyc) begin
            step();
            if (toggle) bus.portStall = ~bus.portStall;
            n++;
        end
        if (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d words pending after %0d cycles, want 0", expQ.size(), maxCyc);
            expQ.delete();
            midPkt = 0;
        end
        bus.portStall = 1'b0;
        repeat (4) step();
    endtask

    int n0;

    initial begin
        reset = 1'b1;
        bus.portStall = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) step();
        chk("reset out", {bus.inValid, bus.inSop, bus.inEop, bus.inData}, '0);
        chk("reset cnt", {bus.dropCnt, bus.errCnt}, '0);
        reset = 1'b0;
        repeat (2) step();

        // 4-word packet: first word two cycles after the eop edge
        sendPkt(32'hA000_0000, 4);
        step();
        chk("a lat1 inValid", bus.inValid, 0);
        step();
        chk("a w0", {bus.inValid, bus.inSop, bus.inEop, bus.inData}, {3'b110, 32'hA000_0000});
        step();
        chk("a w1", {bus.inValid, bus.inSop, bus.inEop, bus.inData}, {3'b100, 32'hA000_0001});
        step();
        chk("a w2", {bus.inValid, bus.inSop, bus.inEop, bus.inData}, {3'b100, 32'hA000_0002});
        step();
        chk("a w3", {bus.inValid, bus.inSop, bus.inEop, bus.inData}, {3'b101, 32'hA000_0003});
        chk("a dropCnt", bus.dropCnt, 0);
        repeat (3) step();

        // single-word packet
        sendPkt(32'hDEAD_BEEF, 1);
        step();
        step();
        chk("b w0", {bus.inValid, bus.inSop, bus.inEop, bus.inData}, {3'b111, 32'hDEAD_BEEF});
        step();
        chk("b after inValid", bus.inValid, 0);
        repeat (3) step();

        // fill under stall, second packet overflows and is dropped
        n0 = issuedCnt;
        bus.portStall = 1'b1;
        sendPkt(32'h3000_0000, DEPTH - 2);
        sendPkt(32'h4000_0000, 5);
        chk("c dropCnt", bus.dropCnt, 1);
        drain(200, 1'b0);
        chk("c issued", issuedCnt - n0, DEPTH - 2);

        // sop while a packet is open aborts it
        n0 = issuedCnt;
        drive(1'b1, 1'b1, 1'b0, 32'h100); step();
        drive(1'b1, 1'b0, 1'b0, 32'h101); step();
        sendPkt(32'h200, 3);
        chk("d errCnt", bus.errCnt, 1);
        drain(200, 1'b0);
        chk("d issued", issuedCnt - n0, 3);

        // back-to-back packets keep arrival order
        n0 = issuedCnt;
        sendPkt(32'h500, 3);
        sendPkt(32'h600, 2);
        drain(200, 1'b0);
        chk("e issued", issuedCnt - n0, 5);

        // stall toggling every cycle
        n0 = issuedCnt;
        sendPkt(32'h700, 8);
        drain(200, 1'b1);
        chk("f issued", issuedCnt - n0, 8);

        // packet longer than the storage is always dropped
        n0 = issuedCnt;
        sendPkt(32'h800, DEPTH + 4);
        chk("g dropCnt", bus.dropCnt, 2);
        repeat (6) step();
        chk("g issued", issuedCnt - n0, 0);

        // orphan words saturate errCnt
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, i == 5, 32'(i));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("h errCnt sat", bus.errCnt, MaxCnt);

        // reset while issuing word 3 of 6
        n0 = issuedCnt;
        sendPkt(32'h900, 6);
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("i rst out", {bus.inValid, bus.inSop, bus.inEop, bus.inData}, '0);
        chk("i rst cnt", {bus.dropCnt, bus.errCnt}, '0);
        reset = 1'b0;
        step();
        chk("i post inValid", bus.inValid, 0);
        repeat (8) step();
        chk("i issued", issuedCnt - n0, 2);
        sendPkt(32'hA00, 2);
        drain(200, 1'b0);
        chk("i issued2", issuedCnt - n0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
